// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 0 when the width does not split into whole digits; the top refuses to elaborate then.
  function automatic int calc_steps(input int width, input int digit);
    if (digit <= 0 || width <= 0 || (width % digit) != 0) return 0;
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_adder_digit_add.sv
// DIGIT-bit full adder slice reused every cycle by seq_adder.
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor with valid/ready handshakes, DIGIT bits per cycle.
// Optional accumulator operand source enabled by defining SEQ_ADDER_ACC_EN.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef SEQ_ADDER_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (STEPS == 0) begin : g_badDigit
    $error("seq_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_sumSh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_carryOut;
  logic             r_overflow;
  logic             r_msbA;
  logic             r_msbB;
  logic             w_accept;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_sumNext;
  logic [DIGIT-1:0] w_d;
  logic             w_c;

`ifdef SEQ_ADDER_ACC_EN
  logic [WIDTH-1:0] r_acc;
  assign w_opA = acc_sel ? r_acc : a;
`else
  assign w_opA = a;
`endif

  // Subtraction is A + ~B + 1, so B is inverted at accept and the carry seeded with sub.
  assign w_opB      = b ^ {WIDTH{sub}};
  assign in_ready   = (r_state == IDLE) & ena & rst_n;
  assign w_accept   = in_valid & in_ready;
  assign w_lastStep = (r_state == RUN) && (r_count == LAST);
  assign w_sumNext  = (r_sumSh >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

  digit_add #(.DIGIT(DIGIT)) u_digitAdd (
    .i_a   (r_aSh[DIGIT-1:0]),
    .i_b   (r_bSh[DIGIT-1:0]),
    .i_cin (r_carry),
    .o_sum (w_d),
    .o_cout(w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_nextState = RUN;
      RUN:  if (r_count == LAST) w_nextState = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result registers only change on the last digit, so they hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_sumSh    <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_msbA     <= 1'b0;
      r_msbB     <= 1'b0;
`ifdef SEQ_ADDER_ACC_EN
      r_acc      <= '0;
`endif
    end else if (ena) begin
      if (w_accept) begin
        r_aSh   <= w_opA;
        r_bSh   <= w_opB;
        r_carry <= sub;
        r_count <= '0;
        r_msbA  <= w_opA[WIDTH-1];
        r_msbB  <= w_opB[WIDTH-1];
      end else if (r_state == RUN) begin
        r_aSh   <= r_aSh >> DIGIT;
        r_bSh   <= r_bSh >> DIGIT;
        r_sumSh <= w_sumNext;
        r_carry <= w_c;
        r_count <= r_count + CNT_W'(1);
        if (w_lastStep) begin
          r_sum      <= w_sumNext;
          r_carryOut <= w_c;
          r_overflow <= (r_msbA == r_msbB) && (w_sumNext[WIDTH-1] != r_msbA);
`ifdef SEQ_ADDER_ACC_EN
          r_acc      <= w_sumNext;
`endif
        end
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench: 8-bit/1-digit instance against a cycle model, 16-bit/4-digit instance against literals.
module tb_seq_adder;

  localparam int STEPS8  = 8;
  localparam int STEPS16 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  sum;
  logic        carry_out;
  logic        overflow;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        sub16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] sum16;
  logic        carry16;
  logic        ovf16;
  logic        ena16 = 1'b1;
`ifdef SEQ_ADDER_ACC_EN
  logic        accSel8 = 1'b0;
  logic        accSel16 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  seq_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
`ifdef SEQ_ADDER_ACC_EN
    .acc_sel(accSel8),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  seq_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16),
`ifdef SEQ_ADDER_ACC_EN
    .acc_sel(accSel16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
    .carry_out(carry16), .overflow(ovf16)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: an operation occupies STEPS enabled cycles, then waits for out_ready.
  int         mRemain = 0;
  bit         mOutValid = 1'b0;
  logic [7:0] mSum = '0;
  bit         mCarry = 1'b0;
  bit         mOvf = 1'b0;
  logic [7:0] pSum;
  bit         pCarry;
  bit         pOvf;

  always @(posedge clk) begin
    int sa;
    int sb;
    int res;
    if (!rst_n) begin
      mRemain = 0; mOutValid = 0; mSum = '0; mCarry = 0; mOvf = 0;
    end else if (ena) begin
      if (mOutValid) begin
        if (out_ready) mOutValid = 0;
      end else if (mRemain > 0) begin
        mRemain--;
        if (mRemain == 0) begin
          mOutValid = 1; mSum = pSum; mCarry = pCarry; mOvf = pOvf;
        end
      end else if (in_valid) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = sub ? sa - sb : sa + sb;
        pSum = sub ? a - b : a + b;
        pCarry = sub ? (a >= b) : ((int'(a) + int'(b)) > 255);
        pOvf = (res > 127) || (res < -128);
        mRemain = STEPS8;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("cmp in_ready", in_ready, (mRemain == 0 && !mOutValid && ena && rst_n));
      check("cmp out_valid", out_valid, mOutValid);
      check("cmp sum", sum, mSum);
      check("cmp carry_out", carry_out, mCarry);
      check("cmp overflow", overflow, mOvf);
    end
  end

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    @(posedge clk); #1;
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] s, input logic c, input logic o);
    check({name, " valid"}, out_valid, 1'b1);
    check({name, " sum"}, sum, s);
    check({name, " carry"}, carry_out, c);
    check({name, " ovf"}, overflow, o);
  endtask

  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " released"}, out_valid, 1'b0);
  endtask

  task automatic run16(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic accSel, input logic [15:0] s,
                       input logic c, input logic o);
    int n;
    @(posedge clk); #1;
    a16 = av; b16 = bv; sub16 = sv; in_valid16 = 1'b1;
`ifdef SEQ_ADDER_ACC_EN
    accSel16 = accSel;
`else
    if (accSel) $display("[TB] note: accumulator select ignored in this build");
`endif
    check({name, " in_ready"}, in_ready16, 1'b1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid16) begin
        n = i;
        break;
      end
    end
    check({name, " latency"}, n, STEPS16);
    check({name, " sum"}, sum16, s);
    check({name, " carry"}, carry16, c);
    check({name, " ovf"}, ovf16, o);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check({name, " released"}, out_valid16, 1'b0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 8'h00);
    check("reset in_ready", in_ready, 1'b0);
    check("reset in_ready16", in_ready16, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", in_ready, 1'b1);

    applyStimulus(8'h35, 8'h0A, 1'b0);
    waitResult(n);
    check("add latency", n, STEPS8);
    checkOutput("35+0A", 8'h3F, 1'b0, 1'b0);
    releaseResult("35+0A");

    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitResult(n);
    checkOutput("FF+01", 8'h00, 1'b1, 1'b0);
    releaseResult("FF+01");

    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitResult(n);
    checkOutput("7F+01", 8'h80, 1'b0, 1'b1);
    releaseResult("7F+01");

    applyStimulus(8'h05, 8'h07, 1'b1);
    waitResult(n);
    checkOutput("05-07", 8'hFE, 1'b0, 1'b0);
    releaseResult("05-07");

    applyStimulus(8'h80, 8'h01, 1'b1);
    waitResult(n);
    checkOutput("80-01", 8'h7F, 1'b1, 1'b1);

    // Backpressure: result must hold while new operands are offered and refused.
    a = 8'h55; b = 8'h11; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("hold valid", out_valid, 1'b1);
      check("hold sum", sum, 8'h7F);
      check("hold in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    releaseResult("backpressure");
    check("idle after release", in_ready, 1'b1);

    // Reset after four RUN cycles discards the operation.
    applyStimulus(8'h11, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun reset valid", out_valid, 1'b0);
    check("midrun reset sum", sum, 8'h00);
    rst_n = 1'b1;
    #1;
    check("after reset in_ready", in_ready, 1'b1);
    applyStimulus(8'h10, 8'h20, 1'b0);
    waitResult(n);
    check("after reset latency", n, STEPS8);
    checkOutput("10+20", 8'h30, 1'b0, 1'b0);
    releaseResult("10+20");

    // Three frozen cycles mid-RUN stretch latency from 8 to 11.
    applyStimulus(8'h0C, 8'h03, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    waitResult(n);
    check("ena stretch latency", n + 5, STEPS8 + 3);
    checkOutput("0C+03", 8'h0F, 1'b0, 1'b0);
    releaseResult("0C+03");

    run16("1234+0FFF", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run16("1000-0001", 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0);
    run16("8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef SEQ_ADDER_ACC_EN
    run16("acc 1+1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    run16("acc+1", 16'h00F0, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
